// File: rtl/orbtrace_pkg.sv
// Shared constants and state encoding for the trace frame controller.
package orbtrace_pkg;

    localparam int FRAME_BITS = 128;
    localparam int WORD_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        COLLECT = 2'd2,
        STORE   = 2'd3
    } state_t;

endpackage

// File: rtl/trace_frame_ctl_if.sv
// Frame handoff to the downstream packer: valid/ready with a full-frame payload.
interface trace_frame_ctl_if
    import orbtrace_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS
);
    logic             FrameValid;
    logic [WIDTH-1:0] Frame;
    logic             FrameReady;

    modport master (output FrameValid, output Frame, input FrameReady);
    modport slave  (input FrameValid, input Frame, output FrameReady);

endinterface

// File: rtl/trace_frame_ctl_fifo.sv
// First-word-fall-through frame FIFO with a registered head (dout/dout_valid).
module frame_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_P = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, wptr_n, rptr_n;
    logic             do_push, do_pop;

    assign full    = (wptr - rptr) == DEPTH_P;
    assign do_pop  = pop & dout_valid;
    assign do_push = push & (~full | do_pop);
    assign wptr_n  = wptr + {{AW{1'b0}}, do_push};
    assign rptr_n  = rptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // The head register is reloaded every cycle; when the new head is the
    // entry being written right now, it has to come straight from din.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            wptr       <= wptr_n;
            rptr       <= rptr_n;
            dout_valid <= (wptr_n != rptr_n);
            if (wptr_n != rptr_n)
                dout <= (do_push && (wptr == rptr_n)) ? din : mem[rptr_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/trace_frame_ctl.sv
// Assembles 16-bit trace words into 128-bit TPIU frames, aligned on PacketReset,
// and queues them for the downstream packer with frame/overflow statistics.
//
//   state   | meaning
//   IDLE    | disabled or out of sync; all input discarded
//   WAIT    | in sync, waiting for PacketReset to establish alignment
//   COLLECT | storing words into the assembly register
//   STORE   | completed frame offered to the FIFO for one cycle
module trace_frame_ctl
    import orbtrace_pkg::*;
#(
    parameter int FRAME_WORDS = 8,
    parameter int DEPTH       = 4,
    parameter int CNTW        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  WdAvail,
    input  logic [WORD_BITS-1:0]  PacketWd,
    input  logic                  PacketReset,
    input  logic                  sync,
    trace_frame_ctl_if.master     frame_out,
    output logic                  Framing,
    output logic [CNTW-1:0]       FrameCnt,
    output logic [CNTW-1:0]       OvfCnt
);
    localparam int              IW   = $clog2(FRAME_WORDS);
    localparam logic [IW-1:0]   LAST = IW'(FRAME_WORDS - 1);

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [WORD_BITS-1:0]   asm_wd [FRAME_WORDS];
    logic [FRAME_BITS-1:0]  frame_q;
    logic                   run, push, pop, full, accept;

    assign run    = enable & sync;
    assign pop    = frame_out.FrameValid & frame_out.FrameReady;
    // A frame completed just before a sync/enable loss is abandoned with the rest.
    assign push   = (state == STORE) & run;
    assign accept = push & (~full | pop);

    assign Framing = (state == COLLECT) && (idx != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            frame_q  <= '0;
            FrameCnt <= '0;
            OvfCnt   <= '0;
            for (int i = 0; i < FRAME_WORDS; i++) asm_wd[i] <= '0;
        end else begin
            if (push) begin
                if (accept) begin
                    if (FrameCnt != '1) FrameCnt <= FrameCnt + CNTW'(1);
                end else begin
                    if (OvfCnt != '1) OvfCnt <= OvfCnt + CNTW'(1);
                end
            end

            if (!run) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                unique case (state)
                    IDLE: state <= WAIT;
                    WAIT: begin
                        if (PacketReset) begin
                            state <= COLLECT;
                            idx   <= '0;
                        end
                    end
                    COLLECT: begin
                        if (PacketReset) begin
                            idx <= '0;
                        end else if (WdAvail) begin
                            asm_wd[idx] <= PacketWd;
                            if (idx == LAST) begin
                                for (int i = 0; i < FRAME_WORDS - 1; i++)
                                    frame_q[i*WORD_BITS +: WORD_BITS] <= asm_wd[i];
                                frame_q[FRAME_BITS-WORD_BITS +: WORD_BITS] <= PacketWd;
                                idx   <= '0;
                                state <= STORE;
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end
                    end
                    STORE: begin
                        state <= COLLECT;
                        if (PacketReset) begin
                            idx <= '0;
                        end else if (WdAvail) begin
                            asm_wd[0] <= PacketWd;
                            idx       <= IW'(1);
                        end else begin
                            idx <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    frame_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .din        (frame_q),
        .pop        (pop),
        .full       (full),
        .dout_valid (frame_out.FrameValid),
        .dout       (frame_out.Frame)
    );

endmodule

// File: tb/tb_trace_frame_ctl.sv
// Self-checking bench for trace_frame_ctl: directed scenarios plus random traffic
// compared every cycle against a queue-based frame model.
module tb_trace_frame_ctl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, WdAvail, PacketReset, sync;
    logic [15:0] PacketWd;
    logic        Framing;
    logic [7:0]  FrameCnt, OvfCnt;

    trace_frame_ctl_if fif ();

    trace_frame_ctl #(.FRAME_WORDS(8), .DEPTH(DEPTH), .CNTW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .WdAvail     (WdAvail),
        .PacketWd    (PacketWd),
        .PacketReset (PacketReset),
        .sync        (sync),
        .frame_out   (fif),
        .Framing     (Framing),
        .FrameCnt    (FrameCnt),
        .OvfCnt      (OvfCnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model: alignment flags, words gathered so far, frame queue
    bit           m_armed, m_aligned, m_pend;
    logic [15:0]  m_words [$];
    logic [127:0] m_fifo [$];
    logic [127:0] m_pend_frame;
    int           m_cnt, m_ovf;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_aligned = 0; m_pend = 0;
        m_words.delete(); m_fifo.delete();
        m_cnt = 0; m_ovf = 0;
    endtask

    task automatic model_step(bit en, bit sy, bit wa, logic [15:0] wd, bit pr, bit rdy);
        bit           pop, run, do_push;
        logic [127:0] f;
        pop     = rdy && (m_fifo.size() > 0);
        run     = en && sy;
        do_push = 0;
        f       = m_pend_frame;
        if (m_pend && run) begin
            if (m_fifo.size() < DEPTH || pop) begin
                do_push = 1;
                if (m_cnt < 255) m_cnt++;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        m_pend = 0;
        if (pop) void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back(f);
        if (!run) begin
            m_armed = 0; m_aligned = 0; m_words.delete();
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (!m_aligned) begin
            if (pr) begin m_aligned = 1; m_words.delete(); end
        end else if (pr) begin
            m_words.delete();
        end else if (wa) begin
            m_words.push_back(wd);
            if (m_words.size() == 8) begin
                for (int i = 0; i < 8; i++) m_pend_frame[i*16 +: 16] = m_words[i];
                m_pend = 1;
                m_words.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", fif.FrameValid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) chk("frame", fif.Frame, m_fifo[0]);
        chk("framing", Framing, m_aligned && m_words.size() != 0);
        chk("frame_cnt", FrameCnt, m_cnt[7:0]);
        chk("ovf_cnt", OvfCnt, m_ovf[7:0]);
    endtask

    task automatic cyc(bit en, bit sy, bit wa, logic [15:0] wd, bit pr, bit rdy);
        @(negedge clk);
        enable = en; sync = sy; WdAvail = wa; PacketWd = wd;
        PacketReset = pr; fif.FrameReady = rdy;
        @(posedge clk);
        model_step(en, sy, wa, wd, pr, rdy);
        #1;
        compare_all();
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 16'h0, 0, rdy);
    endtask

    task automatic words(int n, logic [15:0] base, bit rdy);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, base + 16'(i), 0, rdy);
    endtask

    task automatic preset(bit rdy);
        cyc(1, 1, 0, 16'h0, 1, rdy);
    endtask

    initial begin
        rst = 1'b0; enable = 0; sync = 0; WdAvail = 0; PacketWd = '0;
        PacketReset = 0; fif.FrameReady = 0;
        model_reset();
        #12;
        chk("rst_valid", fif.FrameValid, 0);
        chk("rst_frame", fif.Frame, 0);
        chk("rst_framing", Framing, 0);
        chk("rst_cnt", FrameCnt, 0);
        chk("rst_ovf", OvfCnt, 0);
        @(negedge clk); rst = 1'b1;

        // 1: basic frame, N+2 latency
        idle(1, 1);
        preset(1);
        words(8, 16'h0001, 1);
        chk("t1_lat", fif.FrameValid, 0);
        idle(1, 1);
        chk("t1_valid", fif.FrameValid, 1);
        chk("t1_frame", fif.Frame, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t1_cnt", FrameCnt, 1);
        idle(2, 1);

        // 2: backpressure, DEPTH+1 frames, then drain in order
        for (int k = 0; k < DEPTH + 1; k++) begin
            words(8, 16'h2000 + 16'(k * 16), 0);
            idle(1, 0);
        end
        chk("t2_ovf", OvfCnt, 1);
        chk("t2_head", fif.Frame[15:0], 16'h2000);
        idle(8, 1);

        // 3: partial frame discarded by PacketReset
        words(5, 16'h5000, 1);
        preset(1);
        words(8, 16'hA000, 1);
        idle(3, 1);

        // 4: sync loss mid-frame; words before PacketReset ignored
        words(3, 16'h3000, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 16'h3100 + 16'(i), 0, 1);
        idle(1, 1);
        words(2, 16'h3200, 1);
        preset(1);
        words(8, 16'h4000, 1);
        idle(3, 1);

        // 5: continuous stream; FIFO full with pop in the STORE cycle
        for (int i = 0; i < 48; i++)
            cyc(1, 1, 1, 16'h6000 + 16'(i), 0, i == 40);
        idle(10, 1);

        // 6: async reset mid-frame with a frame waiting
        words(8, 16'h7000, 0);
        idle(1, 0);
        words(3, 16'h7100, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", fif.FrameValid, 0);
        chk("t6_frame", fif.Frame, 0);
        chk("t6_framing", Framing, 0);
        chk("t6_cnt", FrameCnt, 0);
        chk("t6_ovf", OvfCnt, 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        idle(1, 1);
        words(8, 16'h7200, 1);
        idle(2, 1);
        chk("t6_noframe", FrameCnt, 0);
        preset(1);
        words(8, 16'h7300, 1);
        idle(3, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 50) != 0, ($urandom % 40) != 0, $urandom % 2,
                16'($urandom), ($urandom % 30) == 0, ($urandom % 3) != 0);
        idle(10, 1);

        // counter saturation
        idle(1, 1);
        preset(1);
        for (int i = 0; i < 270 * 8; i++) cyc(1, 1, 1, 16'(i), 0, 1);
        idle(3, 1);
        chk("sat_cnt", FrameCnt, 8'hFF);
        for (int i = 0; i < 270 * 8; i++) cyc(1, 1, 1, 16'(i), 0, 0);
        idle(3, 0);
        chk("sat_ovf", OvfCnt, 8'hFF);
        idle(8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
